// File: rtl/cmp_4b_structural.sv
// 4-bit magnitude comparator built from gate-level bit slices, with an optional output register.
// Define CMP_4B_STRUCTURAL_SIGNED_EN for a two's-complement compare; unsigned otherwise.
module cmp_4b_structural #(
  parameter int unsigned REG_OUT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       out_valid,
  output logic       a_is_equal,
  output logic       a_is_greater,
  output logic       a_is_smaller
);

  logic [3:0] w_e;
  logic [3:0] w_g;
  logic [3:0] w_s;
  logic       w_eq;
  logic       w_gt;
  logic       w_lt;

  for (genvar i = 0; i < 4; i++) begin : g_eq_slice
    assign w_e[i] = ~(a[i] ^ b[i]);
  end

  for (genvar i = 0; i < 3; i++) begin : g_mag_slice
    assign w_g[i] = a[i] & ~b[i];
    assign w_s[i] = ~a[i] & b[i];
  end

  // In two's complement a set MSB means negative, so the MSB slice votes the other way.
`ifdef CMP_4B_STRUCTURAL_SIGNED_EN
  assign w_g[3] = ~a[3] & b[3];
  assign w_s[3] = a[3] & ~b[3];
`else
  assign w_g[3] = a[3] & ~b[3];
  assign w_s[3] = ~a[3] & b[3];
`endif

  assign w_eq = &w_e;
  assign w_gt = w_g[3]
              | (w_e[3] & w_g[2])
              | (w_e[3] & w_e[2] & w_g[1])
              | (w_e[3] & w_e[2] & w_e[1] & w_g[0]);
  assign w_lt = w_s[3]
              | (w_e[3] & w_s[2])
              | (w_e[3] & w_e[2] & w_s[1])
              | (w_e[3] & w_e[2] & w_e[1] & w_s[0]);

  if (REG_OUT != 0) begin : g_reg
    logic       r_valid;
    logic [2:0] r_flags;

    // Flags are captured every cycle; only the valid bit follows in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_flags <= '0;
      end else begin
        r_valid <= in_valid;
        r_flags <= {w_eq, w_gt, w_lt};
      end
    end

    assign out_valid    = r_valid;
    assign a_is_equal   = r_flags[2];
    assign a_is_greater = r_flags[1];
    assign a_is_smaller = r_flags[0];
  end else begin : g_comb
    logic w_unused;
    assign w_unused     = &{1'b0, clk, rst_n};
    assign out_valid    = in_valid;
    assign a_is_equal   = w_eq;
    assign a_is_greater = w_gt;
    assign a_is_smaller = w_lt;
  end

endmodule

// File: tb/tb_cmp_4b_structural.sv
// Self-checking bench for cmp_4b_structural: registered and combinational instances
// checked against an integer-arithmetic reference relation.
`timescale 1ns/100ps
module tb_cmp_4b_structural;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;

  logic r_vld, r_eq, r_gt, r_lt;
  logic c_vld, c_eq, c_gt, c_lt;

  int n_tests = 0;
  int n_fail  = 0;

  cmp_4b_structural #(.REG_OUT(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(r_vld), .a_is_equal(r_eq), .a_is_greater(r_gt), .a_is_smaller(r_lt)
  );

  cmp_4b_structural #(.REG_OUT(0)) dut_comb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(c_vld), .a_is_equal(c_eq), .a_is_greater(c_gt), .a_is_smaller(c_lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int val(input logic [3:0] x);
`ifdef CMP_4B_STRUCTURAL_SIGNED_EN
    return x[3] ? int'(x) - 16 : int'(x);
`else
    return int'(x);
`endif
  endfunction

  // {eq, gt, lt} from plain integer ordering
  function automatic logic [2:0] ref_flags(input logic [3:0] x, input logic [3:0] y);
    int vx;
    int vy;
    vx = val(x);
    vy = val(y);
    return {vx == vy, vx > vy, vx < vy};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; a = 4'd5; b = 4'd2;
    @(posedge clk); #1;
    n_tests++;
    if ({r_vld, r_eq, r_gt, r_lt} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_state: got %b want 0000", {r_vld, r_eq, r_gt, r_lt});
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    logic [2:0] exp;
    logic       v;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      a = 4'(i >> 4); b = 4'(i); v = 1'($urandom_range(0, 1)); in_valid = v;
      exp = ref_flags(a, b);
      #2;
      n_tests++;
      if ({c_vld, c_eq, c_gt, c_lt} !== {v, exp}) begin
        n_fail++;
        $display("FAIL sweep_comb a=%0d b=%0d: got %b want %b", a, b, {c_vld, c_eq, c_gt, c_lt}, {v, exp});
      end
      @(posedge clk); #1;
      n_tests++;
      if ({r_vld, r_eq, r_gt, r_lt} !== {v, exp}) begin
        n_fail++;
        $display("FAIL sweep_reg a=%0d b=%0d: got %b want %b", a, b, {r_vld, r_eq, r_gt, r_lt}, {v, exp});
      end
      n_tests++;
      if ((int'(r_eq) + int'(r_gt) + int'(r_lt)) != 1) begin
        n_fail++;
        $display("FAIL onehot a=%0d b=%0d: got %b want exactly one flag", a, b, {r_eq, r_gt, r_lt});
      end
    end
  endtask

  task automatic test_directed();
    logic [3:0] ta [0:8];
    logic [3:0] tb [0:8];
    logic [2:0] te [0:8];
    ta[0] = 4'd9;  tb[0] = 4'd9;  te[0] = 3'b100;
    ta[1] = 4'd8;  tb[1] = 4'd7;
    ta[2] = 4'd6;  tb[2] = 4'd7;  te[2] = 3'b001;
    ta[3] = 4'd0;  tb[3] = 4'd0;  te[3] = 3'b100;
    ta[4] = 4'd15; tb[4] = 4'd15; te[4] = 3'b100;
    ta[5] = 4'd15; tb[5] = 4'd0;
    ta[6] = 4'd0;  tb[6] = 4'd15;
    ta[7] = 4'b1111; tb[7] = 4'b0001;
    ta[8] = 4'b0111; tb[8] = 4'b1000;
`ifdef CMP_4B_STRUCTURAL_SIGNED_EN
    te[1] = 3'b001; te[5] = 3'b001; te[6] = 3'b010; te[7] = 3'b001; te[8] = 3'b010;
`else
    te[1] = 3'b010; te[5] = 3'b010; te[6] = 3'b001; te[7] = 3'b010; te[8] = 3'b001;
`endif
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      a = ta[i]; b = tb[i]; in_valid = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if ({r_vld, r_eq, r_gt, r_lt} !== {1'b1, te[i]}) begin
        n_fail++;
        $display("FAIL directed%0d a=%b b=%b: got %b want %b", i, ta[i], tb[i], {r_vld, r_eq, r_gt, r_lt}, {1'b1, te[i]});
      end
    end
  endtask

  task automatic test_midstream_reset();
    logic [2:0] exp;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 4'($urandom); b = 4'($urandom); in_valid = 1'b1;
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({r_vld, r_eq, r_gt, r_lt} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_async: got %b want 0000", {r_vld, r_eq, r_gt, r_lt});
    end
    @(posedge clk); #1;
    n_tests++;
    if ({r_vld, r_eq, r_gt, r_lt} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_held: got %b want 0000", {r_vld, r_eq, r_gt, r_lt});
    end
    @(negedge clk);
    rst_n = 1'b1; a = 4'd12; b = 4'd3;
    exp = ref_flags(a, b);
    @(posedge clk); #1;
    n_tests++;
    if ({r_vld, r_eq, r_gt, r_lt} !== {1'b1, exp}) begin
      n_fail++;
      $display("FAIL reset_release: got %b want %b", {r_vld, r_eq, r_gt, r_lt}, {1'b1, exp});
    end
  endtask

  task automatic test_valid_pattern();
    logic pat [0:2];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 4'd3; b = 4'd3; in_valid = pat[i];
      @(posedge clk); #1;
      n_tests++;
      if ({r_vld, r_eq, r_gt, r_lt} !== {pat[i], 3'b100}) begin
        n_fail++;
        $display("FAIL valid_pattern%0d: got %b want %b", i, {r_vld, r_eq, r_gt, r_lt}, {pat[i], 3'b100});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ra;
    logic [3:0] rb;
    logic       rv;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ra = 4'($urandom); rb = 4'($urandom); rv = 1'($urandom_range(0, 1));
      a = ra; b = rb; in_valid = rv;
      @(posedge clk); #1;
      n_tests++;
      if ({r_vld, r_eq, r_gt, r_lt} !== {rv, ref_flags(ra, rb)}) begin
        n_fail++;
        $display("FAIL back_to_back a=%0d b=%0d: got %b want %b", ra, rb, {r_vld, r_eq, r_gt, r_lt}, {rv, ref_flags(ra, rb)});
      end
    end
  endtask

  task automatic test_comb();
    @(negedge clk);
    rst_n = 1'b0; a = 4'd12; b = 4'd5; in_valid = 1'b1;
    #1;
    n_tests++;
    if ({c_vld, c_eq, c_gt, c_lt} !== {1'b1, ref_flags(4'd12, 4'd5)}) begin
      n_fail++;
      $display("FAIL comb_zero_latency: got %b want %b", {c_vld, c_eq, c_gt, c_lt}, {1'b1, ref_flags(4'd12, 4'd5)});
    end
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (c_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL comb_valid: got %b want 0", c_vld);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_directed();
    test_midstream_reset();
    test_valid_pattern();
    test_back_to_back();
    test_comb();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
